adder_arbiter: RTL

Round-robin scheduler sharing one combinational 8-bit adder (`adder`) among NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the shared adder from registered operands. It captures the sum and returns it to the granted requester over a valid/ready response handshake. It sits between the requesting masters and the single adder instance and keeps a completed-operation count for the bench and debug.

---
 rtl/adder_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin scheduler that time-shares one combinational
// adder among NREQ requesters, one operation in flight at a time.
module adder_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_operand0,
  input  logic [NREQ*WIDTH-1:0]   req_operand1,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]        resp_result,
  output logic [WIDTH-1:0]        add_operand0,
  output logic [WIDTH-1:0]        add_operand1,
  input  logic [WIDTH-1:0]        add_result,
  output logic                    busy,
  output logic [15:0]             op_count
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;

  logic             scan_found;
  logic [IDX_W-1:0] scan_idx;
  int unsigned      scan_pos;
  logic [IDX_W-1:0] next_ptr;
  logic [WIDTH-1:0] sel_operand0;
  logic [WIDTH-1:0] sel_operand1;

  // Find the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_pos = 32'(rr_ptr) + k;
      if (scan_pos >= NREQ) begin
        scan_pos = scan_pos - NREQ;
      end
      if (!scan_found && req_valid[IDX_W'(scan_pos)]) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(scan_pos);
      end
    end
  end

  // Operands of the candidate winner and the pointer value after its grant.
  always_comb begin
    sel_operand0 = req_operand0[scan_idx*WIDTH +: WIDTH];
    sel_operand1 = req_operand1[scan_idx*WIDTH +: WIDTH];
    if (32'(scan_idx) == NREQ - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = scan_idx + IDX_W'(1);
    end
  end

  // Grant is offered only while idle; it is a one-hot of the scan winner.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && scan_found) begin
      req_ready[scan_idx] = 1'b1;
    end
  end

  // Control FSM plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt          <= '0;
      add_operand0 <= '0;
      add_operand1 <= '0;
      resp_result  <= '0;
      resp_valid   <= '0;
      busy         <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_found) begin
            gnt          <= scan_idx;
            add_operand0 <= sel_operand0;
            add_operand1 <= sel_operand1;
            rr_ptr       <= next_ptr;
            busy         <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          resp_result     <= add_result;
          resp_valid      <= '0;
          resp_valid[gnt] <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (resp_ready[gnt]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            op_count   <= op_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
